// File: rtl/mc_main_ctrl_if.sv
// Control-to-datapath bundle for the multi-cycle main controller.
// MC_MAIN_CTRL_PERF_EN adds the retired-instruction counter signal.
interface mc_main_ctrl_if;
    logic [6:0] opcode;
    logic       mem_ack;
    logic       branch_taken;
    logic [1:0] aluop;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       halted;
    logic       illegal;
    logic       bus_err;
`ifdef MC_MAIN_CTRL_PERF_EN
    logic [31:0] retired;

    modport master (
        input  opcode, mem_ack, branch_taken,
        output aluop, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_req, mem_we, iord, reg_write, wb_sel, halted, illegal,
               bus_err, retired
    );
    modport slave (
        output opcode, mem_ack, branch_taken,
        input  aluop, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_req, mem_we, iord, reg_write, wb_sel, halted, illegal,
               bus_err, retired
    );
`else
    modport master (
        input  opcode, mem_ack, branch_taken,
        output aluop, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_req, mem_we, iord, reg_write, wb_sel, halted, illegal,
               bus_err
    );
    modport slave (
        output opcode, mem_ack, branch_taken,
        input  aluop, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_req, mem_we, iord, reg_write, wb_sel, halted, illegal,
               bus_err
    );
`endif
endinterface

// File: rtl/mc_main_ctrl.sv
// Multi-cycle RISC-V main control FSM with req/ack memory timeout.
// Optional MC_MAIN_CTRL_PERF_EN adds a retired-instruction counter.
module mc_main_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8
) (
    input  logic           clk,
    input  logic           rst,
    mc_main_ctrl_if.master bus
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    // Last count value before the limit; reaching it without an ack is the timeout.
    localparam logic [TO_W-1:0] TO_LIM = TO_W'((MEM_TIMEOUT == 32'd0) ? 32'd0 : MEM_TIMEOUT - 32'd1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_AUIPC, S_WB_ALU, S_ADDR, S_MEM_RD,
        S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_LUI, S_HALT
    } state_t;

    state_t          r_state;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_illegal;
    logic            r_bus_err;
    logic            w_to_hit;

    logic [1:0] w_aluop, w_alu_src_a, w_alu_src_b, w_pc_src, w_wb_sel;
    logic       w_pc_write, w_ir_write, w_mem_req, w_mem_we, w_iord;
    logic       w_reg_write, w_halted;

    assign w_to_hit = (MEM_TIMEOUT != 32'd0) && (r_to_cnt == TO_LIM);

    // State, timeout counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_to_cnt  <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_to_cnt <= '0;
            case (r_state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (bus.mem_ack) begin
                        if (r_state == S_FETCH)       r_state <= S_DECODE;
                        else if (r_state == S_MEM_RD) r_state <= S_WB_MEM;
                        else                          r_state <= S_FETCH;
                    end else if (w_to_hit) begin
                        r_state   <= S_HALT;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE, OP_ITYPE: r_state <= S_EXEC;
                        OP_LOAD, OP_STORE:  r_state <= S_ADDR;
                        OP_BR:              r_state <= S_BRANCH;
                        OP_JAL:             r_state <= S_JAL;
                        OP_JALR:            r_state <= S_JALR;
                        OP_LUI:             r_state <= S_LUI;
                        OP_AUIPC:           r_state <= S_AUIPC;
                        OP_SYS:             r_state <= S_HALT;
                        default: begin
                            r_state   <= S_HALT;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_EXEC, S_AUIPC: r_state <= S_WB_ALU;
                S_ADDR:          r_state <= (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI: r_state <= S_FETCH;
                default:         r_state <= S_HALT;
            endcase
        end
    end

    // Strobe and select decode; everything reads 0 while reset is asserted.
    always_comb begin
        w_aluop     = 2'b00;
        w_alu_src_a = 2'b00;
        w_alu_src_b = 2'b00;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'b00;
        w_ir_write  = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_iord      = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = 2'b00;
        w_halted    = 1'b0;
        if (rst) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req   = 1'b1;
                    w_alu_src_b = 2'b10;
                    w_ir_write  = bus.mem_ack;
                    w_pc_write  = bus.mem_ack;
                end
                S_EXEC: begin
                    w_aluop     = 2'b10;
                    w_alu_src_a = 2'b10;
                    w_alu_src_b = (bus.opcode == OP_RTYPE) ? 2'b00 : 2'b01;
                end
                S_AUIPC: begin
                    w_alu_src_a = 2'b01;
                    w_alu_src_b = 2'b01;
                end
                S_WB_ALU: w_reg_write = 1'b1;
                S_ADDR: begin
                    w_alu_src_a = 2'b10;
                    w_alu_src_b = 2'b01;
                end
                S_MEM_RD: begin
                    w_mem_req = 1'b1;
                    w_iord    = 1'b1;
                end
                S_WB_MEM: begin
                    w_reg_write = 1'b1;
                    w_wb_sel    = 2'b01;
                end
                S_MEM_WR: begin
                    w_mem_req = 1'b1;
                    w_mem_we  = 1'b1;
                    w_iord    = 1'b1;
                end
                S_BRANCH: begin
                    w_aluop     = 2'b01;
                    w_alu_src_a = 2'b10;
                    w_pc_write  = bus.branch_taken;
                    w_pc_src    = 2'b01;
                end
                S_JAL, S_JALR: begin
                    w_reg_write = 1'b1;
                    w_wb_sel    = 2'b10;
                    w_pc_write  = 1'b1;
                    w_pc_src    = (r_state == S_JAL) ? 2'b01 : 2'b10;
                end
                S_LUI: begin
                    w_reg_write = 1'b1;
                    w_wb_sel    = 2'b11;
                end
                S_HALT:  w_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.aluop     = w_aluop;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_src    = w_pc_src;
    assign bus.ir_write  = w_ir_write;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.iord      = w_iord;
    assign bus.reg_write = w_reg_write;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.halted    = w_halted;
    assign bus.illegal   = rst & r_illegal;
    assign bus.bus_err   = rst & r_bus_err;

`ifdef MC_MAIN_CTRL_PERF_EN
    logic        w_retire;
    logic [31:0] r_retired;

    // One count per instruction returning to FETCH; HALT never returns.
    assign w_retire = rst && ((r_state == S_WB_ALU) || (r_state == S_WB_MEM) ||
                              (r_state == S_BRANCH) || (r_state == S_JAL) ||
                              (r_state == S_JALR) || (r_state == S_LUI) ||
                              ((r_state == S_MEM_WR) && bus.mem_ack));

    always_ff @(posedge clk) begin
        if (!rst)          r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 32'd1;
    end

    assign bus.retired = r_retired;
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed self-checking bench for mc_main_ctrl (MEM_TIMEOUT = 4).
module tb_mc_main_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_ret = 0;

    mc_main_ctrl_if bus ();

    mc_main_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected output vector, in the same field order as obs().
    function automatic logic [18:0] pk(input logic [1:0] aluop, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic pcw,
                                       input logic [1:0] pcs, input logic irw,
                                       input logic mreq, input logic mwe, input logic iord,
                                       input logic regw, input logic [1:0] wbs,
                                       input logic hlt, input logic ill, input logic berr);
        return {aluop, sa, sb, pcw, pcs, irw, mreq, mwe, iord, regw, wbs, hlt, ill, berr};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.aluop, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.pc_src,
                bus.ir_write, bus.mem_req, bus.mem_we, bus.iord, bus.reg_write,
                bus.wb_sel, bus.halted, bus.illegal, bus.bus_err};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ack, input logic [6:0] opc, input logic bt);
        bus.mem_ack      = ack;
        bus.opcode       = opc;
        bus.branch_taken = bt;
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] exp;
        rst = 1'b0;
        set_in(1'b1, OP_LUI, 1'b1);
        cyc();
        cyc();
        exp = '0; n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL reset_hold: got %b expected %b", obs(), exp); end
        rst = 1'b1; exp_ret = 0;
        set_in(1'b1, OP_LUI, 1'b0);
        exp = pk(2'b00, 2'b00, 2'b10, 1, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL reset_release_fetch: got %b expected %b", obs(), exp); end
        cyc(); set_in(1'b0, OP_LUI, 1'b0);
        exp = '0; n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL lui_decode: got %b expected %b", obs(), exp); end
        cyc();
        exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL lui_wb: got %b expected %b", obs(), exp); end
        cyc(); exp_ret++;
    endtask

    // Entry and exit: state FETCH, inside the cycle.
    task automatic test_alu(input logic [6:0] opc, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [1:0] aop);
        logic [18:0] exp;
        set_in(1'b1, opc, 1'b0);
        exp = pk(2'b00, 2'b00, 2'b10, 1, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL alu_fetch op=%b: got %b expected %b", opc, obs(), exp); end
        cyc(); set_in(1'b0, opc, 1'b0);
        cyc();
        exp = pk(aop, sa, sb, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL alu_exec op=%b: got %b expected %b", opc, obs(), exp); end
        cyc();
        exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL alu_wb op=%b: got %b expected %b", opc, obs(), exp); end
        cyc(); exp_ret++;
        exp = pk(2'b00, 2'b00, 2'b10, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL alu_next_fetch op=%b: got %b expected %b", opc, obs(), exp); end
    endtask

    task automatic test_load_wait();
        logic [18:0] exp;
        set_in(1'b1, OP_LD, 1'b0);
        cyc(); set_in(1'b0, OP_LD, 1'b0);
        cyc();
        exp = pk(2'b00, 2'b10, 2'b01, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL load_addr: got %b expected %b", obs(), exp); end
        for (int i = 1; i <= 3; i++) begin
            cyc(); set_in((i == 3), OP_LD, 1'b0);
            exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0); n_vec++;
            if (obs() !== exp) begin n_err++; $display("FAIL load_memrd_%0d: got %b expected %b", i, obs(), exp); end
        end
        cyc(); set_in(1'b0, OP_LD, 1'b0);
        exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL load_wb: got %b expected %b", obs(), exp); end
        cyc(); exp_ret++;
    endtask

    task automatic test_store();
        logic [18:0] exp;
        set_in(1'b1, OP_ST, 1'b0);
        cyc(); set_in(1'b0, OP_ST, 1'b0);
        cyc();
        cyc(); set_in(1'b1, OP_ST, 1'b0);
        exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 1, 1, 1, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL store_memwr: got %b expected %b", obs(), exp); end
        cyc(); set_in(1'b0, OP_ST, 1'b0); exp_ret++;
        exp = pk(2'b00, 2'b00, 2'b10, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL store_next_fetch: got %b expected %b", obs(), exp); end
    endtask

    task automatic test_branch(input logic taken);
        logic [18:0] exp;
        set_in(1'b1, OP_BR, 1'b0);
        cyc(); set_in(1'b0, OP_BR, 1'b0);
        cyc(); set_in(1'b0, OP_BR, taken);
        exp = pk(2'b01, 2'b10, 2'b00, taken, 2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL branch_t%0d: got %b expected %b", taken, obs(), exp); end
        cyc(); set_in(1'b0, OP_BR, 1'b0); exp_ret++;
        exp = pk(2'b00, 2'b00, 2'b10, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL branch_t%0d_fetch: got %b expected %b", taken, obs(), exp); end
    endtask

    // mem_ack is held high outside FETCH to show it is ignored there.
    task automatic test_jump(input logic [6:0] opc, input logic [1:0] pcs);
        logic [18:0] exp;
        set_in(1'b1, opc, 1'b0);
        cyc();
        exp = '0; n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL jump_decode_ack op=%b: got %b expected %b", opc, obs(), exp); end
        cyc();
        exp = pk(2'b00, 2'b00, 2'b00, 1, pcs, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL jump_exec op=%b: got %b expected %b", opc, obs(), exp); end
        cyc(); set_in(1'b0, opc, 1'b0); exp_ret++;
    endtask

    task automatic test_timeout_ack_at_limit();
        logic [18:0] exp;
        for (int i = 1; i <= 4; i++) begin
            set_in((i == 4), OP_LUI, 1'b0);
            exp = pk(2'b00, 2'b00, 2'b10, (i == 4), 2'b00, (i == 4), 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
            if (obs() !== exp) begin n_err++; $display("FAIL to_ack4_cycle%0d: got %b expected %b", i, obs(), exp); end
            cyc();
        end
        set_in(1'b0, OP_LUI, 1'b0);
        exp = '0; n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL to_ack4_decode: got %b expected %b", obs(), exp); end
        cyc(); cyc(); exp_ret++;
    endtask

    task automatic test_timeout();
        logic [18:0] exp;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b0, OP_R, 1'b0);
            exp = pk(2'b00, 2'b00, 2'b10, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
            if (obs() !== exp) begin n_err++; $display("FAIL to_wait%0d: got %b expected %b", i, obs(), exp); end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(i[0], OP_R, 1'b1);
            exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1); n_vec++;
            if (obs() !== exp) begin n_err++; $display("FAIL to_halt%0d: got %b expected %b", i, obs(), exp); end
            cyc();
        end
`ifdef MC_MAIN_CTRL_PERF_EN
        n_vec++;
        if (bus.retired !== 32'(exp_ret)) begin n_err++; $display("FAIL to_retired: got %0d expected %0d", bus.retired, exp_ret); end
`endif
    endtask

    task automatic test_halt_op(input logic [6:0] opc, input logic ill);
        logic [18:0] exp;
        set_in(1'b1, opc, 1'b0);
        cyc(); set_in(1'b0, opc, 1'b0);
        cyc();
        exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, ill, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL halt_op=%b: got %b expected %b", opc, obs(), exp); end
        cyc();
        exp = pk(2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, ill, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL halt_sticky_op=%b: got %b expected %b", opc, obs(), exp); end
`ifdef MC_MAIN_CTRL_PERF_EN
        n_vec++;
        if (bus.retired !== 32'(exp_ret)) begin n_err++; $display("FAIL halt_retired_op=%b: got %0d expected %0d", opc, bus.retired, exp_ret); end
`endif
    endtask

    task automatic do_reset();
        logic [18:0] exp;
        rst = 1'b0;
        set_in(1'b0, 7'd0, 1'b0);
        exp = '0; n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL reset_clears: got %b expected %b", obs(), exp); end
        cyc();
        rst = 1'b1; exp_ret = 0;
        set_in(1'b0, 7'd0, 1'b0);
        exp = pk(2'b00, 2'b00, 2'b10, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0); n_vec++;
        if (obs() !== exp) begin n_err++; $display("FAIL reset_refetch: got %b expected %b", obs(), exp); end
    endtask

    initial begin
        test_reset();
        test_alu(OP_R, 2'b10, 2'b00, 2'b10);
        test_alu(OP_I, 2'b10, 2'b01, 2'b10);
        test_alu(OP_AUI, 2'b01, 2'b01, 2'b00);
        test_load_wait();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump(OP_JAL, 2'b01);
        test_jump(OP_JR, 2'b10);
        test_timeout_ack_at_limit();
        test_timeout();
        do_reset();
        test_halt_op(OP_BAD, 1'b1);
        do_reset();
        test_alu(OP_R, 2'b10, 2'b00, 2'b10);
        test_halt_op(OP_SYS, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multi-cycle main control FSM for the RISC-V core. It decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback.
- It is the producer of the 2-bit aluop consumed by the ALU control decoder: 00 = add, 01 = subtract/compare, 10 = funct-decoded. 11 is never driven.
- It also drives register-file, PC, IR and memory strobes, and a req/ack memory handshake with timeout.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before bus error; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- opcode  in  7  instr[6:0] from the IR (valid from DECODE onward).
- mem_ack  in  1  memory completes the current request this cycle.
- branch_taken  in  1  external comparator result, valid in BRANCH.
- aluop  out  2  to the ALU control decoder.
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- pc_write  out  1  PC load strobe.
- pc_src  out  2  00 = ALU result, 01 = old_pc+imm, 10 = (rs1+imm)&~1.
- ir_write  out  1  IR and old_pc load strobe.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  store request.
- iord  out  1  0 = address from PC, 1 = address from ALU out.
- reg_write  out  1  register-file write strobe.
- wb_sel  out  2  00 = ALU out, 01 = mem data, 10 = old_pc+4, 11 = imm.
- halted  out  1  sticky halt flag.
- illegal  out  1  sticky: halted on an unknown opcode.
- bus_err  out  1  sticky: halted on a memory timeout.

Behaviour:
- Reset: while rst=0 at an edge, next state = FETCH and the timeout counter is cleared. halted, illegal and bus_err clear to 0. All strobes and selects decode to 0 during the reset cycle.
- Outputs are combinational from state, plus mem_ack and branch_taken where noted. Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=10, aluop=00.
  - On mem_ack: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE dispatches on opcode:
  - 0110011 or 0010011 -> EXEC.
  - 0000011 or 0100011 -> ADDR.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - 0010111 -> AUIPC.
  - 1110011 -> HALT with illegal=0.
  - Anything else -> HALT with illegal set.
- EXEC: aluop=10, alu_src_a=10, alu_src_b=00 for R-type or 01 for I-type; -> WB_ALU.
- AUIPC: aluop=00, alu_src_a=01, alu_src_b=01; -> WB_ALU.
- WB_ALU: reg_write=1, wb_sel=00; -> FETCH.
- ADDR: aluop=00, alu_src_a=10, alu_src_b=01; -> MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, iord=1; stays until mem_ack, then -> WB_MEM.
- WB_MEM: reg_write=1, wb_sel=01; -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; stays until mem_ack, then -> FETCH.
- BRANCH: aluop=01, alu_src_a=10, alu_src_b=00. pc_write=branch_taken, pc_src=01. -> FETCH.
- JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=01; -> FETCH.
- JALR: reg_write=1, wb_sel=10, pc_write=1, pc_src=10; -> FETCH.
- LUI: reg_write=1, wb_sel=11; -> FETCH.
- HALT: absorbing; all strobes 0, halted=1. Only reset exits.
- Timeout:
  - The counter increments each cycle mem_req=1 and mem_ack=0, and clears on ack or on a state change.
  - When it reaches MEM_TIMEOUT (MEM_TIMEOUT>0), with no ack that cycle, go to HALT and set bus_err.
  - If the ack arrives in the same cycle as the limit, the ack wins.
- Cycle counts excluding memory waits: loads 5, stores 4, ALU/AUIPC 4, branch/JAL/JALR/LUI 3.
- mem_ack outside FETCH, MEM_RD and MEM_WR is ignored.

Optional Feature:
- Macro MC_MAIN_CTRL_PERF_EN.
- When defined: adds output retired[31:0]. It clears on reset and increments by 1 on every transition into FETCH from a non-FETCH, non-reset state (one per completed instruction). It wraps at 2^32, does not count in HALT, and does not count the HALT-causing instruction.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release, mem_ack=1 immediately -> state FETCH on release; ir_write=1 and pc_write=1 in that cycle; halted=bus_err=illegal=0.
- R-type: opcode 0110011, ack on first FETCH cycle -> aluop=10 in EXEC (cycle 3), reg_write=1 with wb_sel=00 in cycle 4, mem_req=1 again in cycle 5.
- Load with 3-cycle memory wait: opcode 0000011, mem_ack asserted on the 3rd MEM_RD cycle -> mem_req=1 and iord=1 for exactly 3 cycles, then reg_write=1 with wb_sel=01.
- Branch: opcode 1100011 -> aluop=01; branch_taken=1 gives pc_write=1, pc_src=01; branch_taken=0 gives pc_write=0. Both return to FETCH next cycle.
- Timeout: MEM_TIMEOUT=4, mem_ack never asserted in FETCH -> halted=1 and bus_err=1 after 4 waiting cycles; strobes remain 0 until rst=0. Repeat with ack on cycle 4 -> no error.
- Illegal opcode 1111111 -> HALT with illegal=1. Opcode 1110011 -> halted=1, illegal=0. With the macro defined, retired = instructions completed before the halt.
